// File: rtl/layer_sched_pkg.sv
// Shared types, widths and width helpers for the layer scheduler.
package layer_sched_pkg;

  localparam int unsigned DATA_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_RDY,
    DRAIN,
    FIN
  } state_e;

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n items (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sched_beat_counter.sv
// Terminal-count counter: hit_c flags the increment that reaches MAX_CNT,
// at which point the count wraps back to zero.
module sched_beat_counter
  import layer_sched_pkg::*;
#(
  parameter int unsigned MAX_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_c
);

  localparam int unsigned CW = cnt_w(MAX_CNT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign hit_c = inc_i && !clr_i && (cnt_q == CW'(MAX_CNT - 1));

  // Next count: clear wins, terminal increment returns to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || hit_c) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/layer_scheduler.sv
// Sequences one convolution layer: per channel, load a burst of preload
// words into the accelerator, wait for channel_ready, then drain the ReLU
// output beats. Optional watchdog: define LAYER_SCHED_WDT_EN.
module layer_scheduler
  import layer_sched_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS          = 64,
  parameter int unsigned WORDS_PER_CHANNEL     = 256,
  parameter int unsigned OUT_BEATS_PER_CHANNEL = 16384,
  parameter int unsigned WDT_CYCLES            = 65536
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [$clog2(NUM_CHANNELS):0]    cfg_num_channels,
  input  logic                             src_valid,
  input  logic [DATA_W-1:0]                src_data,
  output logic                             src_ready,
  output logic                             acc_scatter_valid,
  output logic [DATA_W-1:0]                acc_scatter_data,
  input  logic                             acc_channel_ready,
  input  logic                             acc_out_valid,
  output logic                             busy,
  output logic                             done,
  output logic [idx_w(NUM_CHANNELS)-1:0]   channel_idx,
  output logic                             err_stray,
  output logic                             err_timeout
);

  localparam int unsigned IDX_W = idx_w(NUM_CHANNELS);
  localparam int unsigned CFG_W = $clog2(NUM_CHANNELS) + 1;

  // Zero-length counters would never hit; reject at elaboration.
  if (NUM_CHANNELS == 0 || WORDS_PER_CHANNEL == 0 ||
      OUT_BEATS_PER_CHANNEL == 0 || WDT_CYCLES == 0) begin : g_bad_cfg
    $error("layer_scheduler: channel, word, beat and watchdog limits must be non-zero");
  end

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               src_ready_q, src_ready_d;
  logic               sv_q, sv_d;
  logic [DATA_W-1:0]  sd_q, sd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               stray_q, stray_d;
  logic               to_q, to_d;

  logic src_hs;
  logic word_hit;
  logic beat_hit;
  logic wdt_hit;
  logic last_ch;

  assign src_hs  = src_valid && src_ready_q;
  assign last_ch = (CFG_W'(idx_q) == (cfg_q - CFG_W'(1)));

  // Preload words per channel; held at zero outside LOAD.
  sched_beat_counter #(.MAX_CNT(WORDS_PER_CHANNEL)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (src_hs),
    .clr_i (state_q != LOAD),
    .hit_c (word_hit)
  );

  // Output beats per channel; stray beats outside DRAIN are not counted.
  sched_beat_counter #(.MAX_CNT(OUT_BEATS_PER_CHANNEL)) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i ((state_q == DRAIN) && acc_out_valid),
    .clr_i (state_q != DRAIN),
    .hit_c (beat_hit)
  );

`ifdef LAYER_SCHED_WDT_EN
  logic wdt_run;
  logic wdt_clr;

  // Idle-cycle watchdog over the two open-ended waits; restarts on any
  // state change (WAIT_RDY leaves on ready, DRAIN only on a beat) or beat.
  assign wdt_run = (state_q == WAIT_RDY) || (state_q == DRAIN);
  assign wdt_clr = !wdt_run || acc_out_valid ||
                   ((state_q == WAIT_RDY) && acc_channel_ready);

  sched_beat_counter #(.MAX_CNT(WDT_CYCLES)) u_wdt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (wdt_run),
    .clr_i (wdt_clr),
    .hit_c (wdt_hit)
  );
`else
  assign wdt_hit = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    stray_d = stray_q;
    to_d    = to_q;
    sv_d    = src_hs;
    sd_d    = src_hs ? src_data : sd_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          stray_d = 1'b0;
          to_d    = 1'b0;
          if (cfg_num_channels != '0) begin
            cfg_d   = cfg_num_channels;
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            state_d = FIN;
          end
        end
      end
      LOAD: begin
        if (word_hit) begin
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (acc_channel_ready) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (beat_hit) begin
          if (last_ch) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (wdt_hit) begin
      to_d    = 1'b1;
      state_d = FIN;
    end

    if (acc_out_valid && (state_q != DRAIN)) begin
      stray_d = 1'b1;
    end

    src_ready_d = (state_d == LOAD);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      idx_q       <= '0;
      src_ready_q <= 1'b0;
      sv_q        <= 1'b0;
      sd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stray_q     <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      idx_q       <= idx_d;
      src_ready_q <= src_ready_d;
      sv_q        <= sv_d;
      sd_q        <= sd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stray_q     <= stray_d;
      to_q        <= to_d;
    end
  end

  assign src_ready         = src_ready_q;
  assign acc_scatter_valid = sv_q;
  assign acc_scatter_data  = sd_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign channel_idx       = idx_q;
  assign err_stray         = stray_q;
  assign err_timeout       = to_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench for layer_scheduler (small parameters so layers are short).
module tb_layer_scheduler;

  localparam int NCH = 4;
  localparam int W   = 4;
  localparam int B   = 3;
  localparam int WDT = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   cfg_num_channels;
  logic         src_valid;
  logic [127:0] src_data;
  logic         src_ready;
  logic         acc_scatter_valid;
  logic [127:0] acc_scatter_data;
  logic         acc_channel_ready;
  logic         acc_out_valid;
  logic         busy;
  logic         done;
  logic [1:0]   channel_idx;
  logic         err_stray;
  logic         err_timeout;

  layer_scheduler #(
    .NUM_CHANNELS          (NCH),
    .WORDS_PER_CHANNEL     (W),
    .OUT_BEATS_PER_CHANNEL (B),
    .WDT_CYCLES            (WDT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .cfg_num_channels  (cfg_num_channels),
    .src_valid         (src_valid),
    .src_data          (src_data),
    .src_ready         (src_ready),
    .acc_scatter_valid (acc_scatter_valid),
    .acc_scatter_data  (acc_scatter_data),
    .acc_channel_ready (acc_channel_ready),
    .acc_out_valid     (acc_out_valid),
    .busy              (busy),
    .done              (done),
    .channel_idx       (channel_idx),
    .err_stray         (err_stray),
    .err_timeout       (err_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural view of the layer: which phase the spec says we are in,
  // plus the words accepted so far (scoreboard of expected scatter data).
  typedef enum {M_IDLE, M_LOAD, M_WAIT, M_DRAIN, M_FIN} mph_e;
  mph_e         m_ph = M_IDLE;
  int           m_ch = 0;
  int           m_cfg = 0;
  int           m_words = 0;
  int           m_beats = 0;
  bit           m_stray = 1'b0;
  bit           prev_hs = 1'b0;
  logic [127:0] sb_q[$];

  typedef struct {
    int cfg;
    int src_mode;   // 0: random gaps, 1: alternate 1,0,1,0
    int gap;
    int rdy;
    int beat;
    bit stray;
    bit noise;
    int exp_words;
    int exp_done;
    int exp_idx;
    bit exp_stray;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic model_clear();
    m_ph = M_IDLE; m_ch = 0; m_cfg = 0; m_words = 0; m_beats = 0;
    m_stray = 1'b0; prev_hs = 1'b0;
    sb_q.delete();
  endtask

  task automatic quiet_inputs();
    start = 1'b0; cfg_num_channels = '0; src_valid = 1'b0; src_data = '0;
    acc_channel_ready = 1'b0; acc_out_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, 128'({src_ready, busy, done, acc_scatter_valid, channel_idx, err_stray, err_timeout}), 128'(0));
    chk({name, "_data"}, acc_scatter_data, 128'(0));
  endtask

  // Compare every output against the behavioural view for the current cycle.
  task automatic check_cycle(input int cyc);
    logic [7:0]   act, exp;
    logic [127:0] d;
    act = {src_ready, busy, done, acc_scatter_valid, channel_idx, err_stray, err_timeout};
    exp = {m_ph == M_LOAD, m_ph != M_IDLE, m_ph == M_FIN, prev_hs, 2'(m_ch), m_stray, 1'b0};
    chk($sformatf("cycle%0d_outputs", cyc), 128'(act), 128'(exp));
    if (acc_scatter_valid) begin
      if (sb_q.size() == 0) begin
        chk($sformatf("cycle%0d_scatter_unexpected", cyc), 128'(1), 128'(0));
      end else begin
        d = sb_q.pop_front();
        chk($sformatf("cycle%0d_scatter_data", cyc), acc_scatter_data, d);
      end
    end
  endtask

  // Advance the behavioural view by one cycle given the inputs just applied.
  task automatic model_step(input bit st, input int cfg, input bit sv, input logic [127:0] sd,
                            input bit rdy, input bit ov);
    bit hs;
    hs = sv && (m_ph == M_LOAD);
    prev_hs = hs;
    if (hs) sb_q.push_back(sd);
    if (m_ph == M_IDLE && st) m_stray = 1'b0;
    if (ov && m_ph != M_DRAIN) m_stray = 1'b1;
    case (m_ph)
      M_IDLE:  if (st) begin
                 if (cfg > 0) begin m_cfg = cfg; m_ch = 0; m_ph = M_LOAD; end
                 else m_ph = M_FIN;
               end
      M_LOAD:  if (sv) begin
                 m_words++;
                 if (m_words == W) begin m_words = 0; m_ph = M_WAIT; end
               end
      M_WAIT:  if (rdy) m_ph = M_DRAIN;
      M_DRAIN: if (ov) begin
                 m_beats++;
                 if (m_beats == B) begin
                   m_beats = 0;
                   if (m_ch == m_cfg - 1) m_ph = M_FIN;
                   else begin m_ch++; m_ph = M_LOAD; end
                 end
               end
      default: m_ph = M_IDLE;
    endcase
  endtask

  // Drive one full layer as source + accelerator, checking every cycle.
  task automatic run_layer(input int cfg, input int src_mode, input int gap, input int rdy_pct,
                           input int beat_pct, input bit stray_en, input bit noise_en,
                           input int abort_ch, output int n_words, output int n_done);
    bit finished = 1'b0;
    bit stray_done = 1'b0;
    n_words = 0;
    n_done  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0) || (noise_en && m_ph != M_IDLE && $urandom_range(99) < 20);
      cfg_num_channels = (cyc == 0) ? 3'(cfg) : 3'($urandom_range(7));
      src_valid = (src_mode == 1) ? (cyc % 2 == 1) : ($urandom_range(99) >= gap);
      src_data  = {$urandom, $urandom, $urandom, $urandom};
      acc_channel_ready = ($urandom_range(99) < rdy_pct);
      acc_out_valid = (m_ph == M_DRAIN) && ($urandom_range(99) < beat_pct);
      if (stray_en && !stray_done && m_ph == M_LOAD) begin
        acc_out_valid = 1'b1;
        stray_done = 1'b1;
      end
      @(negedge clk);
      check_cycle(cyc);
      n_done += int'(done);
      if (src_valid && src_ready) n_words++;
      if (abort_ch >= 0 && m_ph == M_DRAIN && m_ch == abort_ch) begin
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        quiet_inputs();
        model_clear();
        @(negedge clk); #2 rst_n = 1'b1;
        finished = 1'b1;
        break;
      end
      model_step(start, cfg, src_valid, src_data, acc_channel_ready, acc_out_valid);
      if (m_ph == M_IDLE) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) chk("layer_cycle_budget", 128'(0), 128'(1));
    // One quiet cycle to confirm the block settled in IDLE.
    @(posedge clk); #1;
    quiet_inputs();
    @(negedge clk);
    check_cycle(-1);
    n_done += int'(done);
    model_step(1'b0, 0, 1'b0, '0, 1'b0, 1'b0);
    chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
  endtask

  vec_t vecs[7];
  int   nw, nd, exp_idx;

  initial begin
    quiet_inputs();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #4 chk_all_zero("reset_values");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    model_clear();

    //          cfg mode gap rdy beat stray noise words done idx stray
    vecs[0] = '{2, 0,  0, 100, 100, 1'b0, 1'b0,  8, 1, 1, 1'b0};  // smoke
    vecs[1] = '{1, 1,  0, 100, 100, 1'b0, 1'b0,  4, 1, 0, 1'b0};  // 1,0,1,0 gaps
    vecs[2] = '{0, 0,  0, 100, 100, 1'b0, 1'b0,  0, 1, 0, 1'b0};  // empty layer
    vecs[3] = '{2, 0, 30,  50,  70, 1'b1, 1'b0,  8, 1, 1, 1'b1};  // stray in LOAD
    vecs[4] = '{3, 0, 20,  60,  60, 1'b0, 1'b1, 12, 1, 2, 1'b0};  // starts while busy
    vecs[5] = '{4, 0, 60,  20,  40, 1'b0, 1'b0, 16, 1, 3, 1'b0};  // slow everything
    vecs[6] = '{1, 0,  0,  30, 100, 1'b1, 1'b1,  4, 1, 0, 1'b1};

    foreach (vecs[i]) begin
      run_layer(vecs[i].cfg, vecs[i].src_mode, vecs[i].gap, vecs[i].rdy, vecs[i].beat,
                vecs[i].stray, vecs[i].noise, -1, nw, nd);
      chk($sformatf("vec%0d_words", i), 128'(nw), 128'(vecs[i].exp_words));
      chk($sformatf("vec%0d_done", i), 128'(nd), 128'(vecs[i].exp_done));
      chk($sformatf("vec%0d_idx", i), 128'(channel_idx), 128'(vecs[i].exp_idx));
      chk($sformatf("vec%0d_stray", i), 128'(err_stray), 128'(vecs[i].exp_stray));
    end

    // Reset during DRAIN of channel 1, then a clean layer afterwards.
    run_layer(2, 0, 0, 100, 50, 1'b0, 1'b0, 1, nw, nd);
    chk("abort_no_done", 128'(nd), 128'(0));
    exp_idx = 0;

    for (int r = 0; r < 25; r++) begin
      int  cfg;
      bit  st;
      cfg = $urandom_range(NCH);
      st  = 1'($urandom_range(1));
      run_layer(cfg, 0, $urandom_range(70), $urandom_range(90, 20), $urandom_range(90, 30),
                st, 1'($urandom_range(1)), -1, nw, nd);
      if (cfg > 0) exp_idx = cfg - 1;
      chk($sformatf("rand%0d_words", r), 128'(nw), 128'(cfg * W));
      chk($sformatf("rand%0d_done", r), 128'(nd), 128'(1));
      chk($sformatf("rand%0d_idx", r), 128'(channel_idx), 128'(exp_idx));
      chk($sformatf("rand%0d_stray", r), 128'(err_stray), 128'(st && cfg > 0));
    end

    // Hold channel_ready low after one channel load.
    @(posedge clk); #1;
    start = 1'b1; cfg_num_channels = 3'd1; src_valid = 1'b1; src_data = '1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 src_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
`ifdef LAYER_SCHED_WDT_EN
      chk($sformatf("wdt_cycle%0d", i), 128'({src_ready, busy, done, err_timeout}),
          128'({1'b0, i <= 17, i == 17, i >= 17}));
`else
      chk($sformatf("hold_cycle%0d", i), 128'({src_ready, busy, done, err_timeout}),
          128'(4'b0100));
`endif
      @(posedge clk);
    end
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk_all_zero("final_reset");
    quiet_inputs();
    @(negedge clk); #2 rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
